// File: rtl/single_port_sram_arbiter.sv
// Round-robin arbiter sharing one single-port, bit-masked SRAM macro between NUM_REQ requesters.
// Grants and macro pins are combinational; read data returns one cycle after the grant.
module single_port_sram_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int WIDTH    = 128,
    parameter int NUM_ROWS = 4096,
    localparam int AddressWidth = $clog2(NUM_ROWS),
    localparam int IdWidth      = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*AddressWidth-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]        req_data,
    input  logic [NUM_REQ*WIDTH-1:0]        req_mask,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [WIDTH-1:0]                rsp_data,
    output logic                            sram_ceb,
    output logic                            sram_web,
    output logic [AddressWidth-1:0]         sram_a,
    output logic [WIDTH-1:0]                sram_d,
    output logic [WIDTH-1:0]                sram_m,
    input  logic [WIDTH-1:0]                sram_q
);

    logic [IdWidth-1:0] rr_ptr;
    logic [IdWidth-1:0] ptr_next;
    logic [IdWidth-1:0] winner;
    logic [IdWidth-1:0] rd_id;
    logic               rd_pend;
    logic               found;
    logic               grant;
    int                 scan_idx;

    // Search from rr_ptr upward, wrapping explicitly so non-power-of-two counts work.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = IdWidth'(scan_idx);
            end
        end
    end

    // Reset masks the grant so the macro stays deselected while rst_n is low.
    assign grant = found & rst_n;

    always_comb begin
        req_ready = '0;
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_a    = '0;
        sram_d    = '0;
        sram_m    = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
            sram_ceb          = 1'b0;
            sram_web          = ~req_write[winner];
            sram_a            = req_addr[int'(winner)*AddressWidth +: AddressWidth];
            sram_d            = req_data[int'(winner)*WIDTH +: WIDTH];
            sram_m            = req_mask[int'(winner)*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        if (int'(winner) == NUM_REQ - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = winner + IdWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            rd_pend <= 1'b0;
            rd_id   <= '0;
        end else begin
            rd_pend <= grant & ~req_write[winner];
            if (grant) begin
                rr_ptr <= ptr_next;
                rd_id  <= winner;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rd_pend) begin
            rsp_valid[rd_id] = 1'b1;
        end
    end

    // The macro registers Q internally, so read data passes straight through.
    assign rsp_data = sram_q;

endmodule

// File: tb/tb_single_port_sram_arbiter.sv
// Bench for single_port_sram_arbiter: a 2-requester instance for directed and table tests,
// a 3-requester instance for pointer wrap and randomized checking against a reference model.
module tb_single_port_sram_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Instance A: NUM_REQ=2, WIDTH=128, NUM_ROWS=256
    logic [1:0]   a_valid, a_ready, a_write, a_rsp_valid;
    logic [15:0]  a_addr;
    logic [255:0] a_data, a_mask;
    logic [127:0] a_rsp_data, a_sd, a_sm;
    logic [127:0] a_q = '0;
    logic         a_ceb, a_web;
    logic [7:0]   a_sa;
    logic [127:0] mem_a [256] = '{default: '0};

    single_port_sram_arbiter #(.NUM_REQ(2), .WIDTH(128), .NUM_ROWS(256)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_addr(a_addr), .req_data(a_data), .req_mask(a_mask),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
        .sram_ceb(a_ceb), .sram_web(a_web), .sram_a(a_sa), .sram_d(a_sd), .sram_m(a_sm),
        .sram_q(a_q)
    );

    // Instance B: NUM_REQ=3, WIDTH=16, NUM_ROWS=16
    logic [2:0]  b_valid, b_ready, b_write, b_rsp_valid;
    logic [11:0] b_addr;
    logic [47:0] b_data, b_mask;
    logic [15:0] b_rsp_data, b_sd, b_sm;
    logic [15:0] b_q = '0;
    logic        b_ceb, b_web;
    logic [3:0]  b_sa;
    logic [15:0] mem_b [16] = '{default: '0};

    single_port_sram_arbiter #(.NUM_REQ(3), .WIDTH(16), .NUM_ROWS(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_addr(b_addr), .req_data(b_data), .req_mask(b_mask),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .sram_ceb(b_ceb), .sram_web(b_web), .sram_a(b_sa), .sram_d(b_sd), .sram_m(b_sm),
        .sram_q(b_q)
    );

    // Behavioural SRAM macros: mask bit 1 keeps, 0 overwrites; Q holds while CEB is high.
    always @(posedge clk) begin
        if (!a_ceb) begin
            if (!a_web) mem_a[a_sa] <= (mem_a[a_sa] & a_sm) | (a_sd & ~a_sm);
            else        a_q <= mem_a[a_sa];
        end
        if (!b_ceb) begin
            if (!b_web) mem_b[b_sa] <= (mem_b[b_sa] & b_sm) | (b_sd & ~b_sm);
            else        b_q <= mem_b[b_sa];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [1:0] write;
        logic [1:0] exp_ready;
        logic       exp_ceb;
        logic       exp_web;
        logic [1:0] exp_rsp;
    } vec_t;

    vec_t vecs [8];

    // Reference model state for the randomized run on instance B
    logic [15:0] ref_mem [16];
    bit          pv [3];
    bit          pw [3];
    logic [3:0]  pa [3];
    logic [15:0] pd [3];
    logic [15:0] pm [3];

    initial begin
        int ptr;
        int gw;
        bit gv;
        logic [2:0]  exp_rv;
        logic [15:0] exp_rd;

        vecs[0] = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 2'b00};
        vecs[1] = '{2'b11, 2'b11, 2'b10, 1'b0, 1'b0, 2'b01};
        vecs[2] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00};
        vecs[3] = '{2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 2'b00};
        vecs[4] = '{2'b11, 2'b01, 2'b01, 1'b0, 1'b0, 2'b10};
        vecs[5] = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 2'b00};
        vecs[6] = '{2'b11, 2'b00, 2'b10, 1'b0, 1'b1, 2'b01};
        vecs[7] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10};

        a_valid = '0; a_write = '0; a_addr = '0; a_data = '0; a_mask = '0;
        b_valid = '0; b_write = '0; b_addr = '0; b_data = '0; b_mask = '0;

        // Reset values with every requester asserting valid
        rst_n = 1'b0;
        a_valid = 2'b11; a_write = 2'b11;
        b_valid = 3'b111;
        #1;
        chk("rst_a_ceb", 128'(a_ceb), 128'(1'b1));
        chk("rst_a_web", 128'(a_web), 128'(1'b1));
        chk("rst_a_ready", 128'(a_ready), 128'(2'b00));
        chk("rst_b_ready", 128'(b_ready), 128'(3'b000));
        tick();
        tick();
        chk("rst_a_rsp", 128'(a_rsp_valid), 128'(2'b00));
        chk("rst_b_ceb", 128'(b_ceb), 128'(1'b1));
        a_write = 2'b00;
        b_valid = 3'b000;
        rst_n = 1'b1;
        #1;
        chk("post_rst_first_grant", 128'(a_ready), 128'(2'b01));
        a_valid = 2'b00;

        // Requester 1 writes then reads 0x10
        tick();
        a_valid = 2'b10; a_write = 2'b10;
        a_addr[15:8] = 8'h10; a_data[255:128] = {16{8'hA5}}; a_mask[255:128] = '0;
        #1;
        chk("rt_wr_ready", 128'(a_ready), 128'(2'b10));
        chk("rt_wr_web", 128'(a_web), 128'(1'b0));
        chk("rt_wr_addr", 128'(a_sa), 128'(8'h10));
        chk("rt_wr_data", a_sd, {16{8'hA5}});
        tick();
        a_write = 2'b00;
        #1;
        chk("rt_rd_ready", 128'(a_ready), 128'(2'b10));
        chk("rt_rd_web", 128'(a_web), 128'(1'b1));
        chk("rt_rd_no_early_rsp", 128'(a_rsp_valid), 128'(2'b00));
        tick();
        a_valid = 2'b00;
        #1;
        chk("rt_rsp_valid", 128'(a_rsp_valid), 128'(2'b10));
        chk("rt_rsp_data", a_rsp_data, {16{8'hA5}});
        tick();
        chk("rt_rsp_one_pulse", 128'(a_rsp_valid), 128'(2'b00));

        // Masked write over zeros, then read back
        a_valid = 2'b01; a_write = 2'b01;
        a_addr[7:0] = 8'h20; a_data[127:0] = '1; a_mask[127:0] = 128'hF;
        #1;
        chk("mw_ready", 128'(a_ready), 128'(2'b01));
        chk("mw_mask", a_sm, 128'hF);
        tick();
        a_write = 2'b00;
        #1;
        chk("mw_rd_ready", 128'(a_ready), 128'(2'b01));
        tick();
        a_valid = 2'b00;
        #1;
        chk("mw_rsp_valid", 128'(a_rsp_valid), 128'(2'b01));
        chk("mw_rsp_data", a_rsp_data, ~128'hF);

        // Fairness: both valid reading distinct addresses; pointer currently at 1
        tick();
        a_valid = 2'b11; a_write = 2'b00;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", 128'(a_ready), (k % 2 == 0) ? 128'(2'b10) : 128'(2'b01));
            if (k > 0) begin
                chk("rr_rsp_valid", 128'(a_rsp_valid), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
                chk("rr_rsp_data", a_rsp_data, (k % 2 == 0) ? ~128'hF : {16{8'hA5}});
            end
            tick();
        end
        a_valid = 2'b00;
        #1;
        chk("rr_last_rsp", 128'(a_rsp_valid), 128'(2'b01));
        chk("rr_last_data", a_rsp_data, ~128'hF);

        // Reset between a read grant and its edge; pointer was 1 before reset
        tick();
        a_valid = 2'b01;
        #1;
        chk("mid_rd_grant", 128'(a_ready), 128'(2'b01));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 128'(a_ready), 128'(2'b00));
        chk("mid_rst_ceb", 128'(a_ceb), 128'(1'b1));
        tick();
        chk("mid_rst_rsp0", 128'(a_rsp_valid), 128'(2'b00));
        tick();
        chk("mid_rst_rsp1", 128'(a_rsp_valid), 128'(2'b00));
        a_valid = 2'b11;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ptr_zero", 128'(a_ready), 128'(2'b01));
        chk("mid_rst_rsp2", 128'(a_rsp_valid), 128'(2'b00));
        a_valid = 2'b00;

        // Table-driven sequence from pointer 0; writes keep every bit so memory is unchanged
        a_addr = {8'h31, 8'h30}; a_data = '0; a_mask = '1;
        tick();
        for (int r = 0; r < 8; r++) begin
            a_valid = vecs[r].valid;
            a_write = vecs[r].write;
            #1;
            chk($sformatf("vec%0d_ready", r), 128'(a_ready), 128'(vecs[r].exp_ready));
            chk($sformatf("vec%0d_ceb", r), 128'(a_ceb), 128'(vecs[r].exp_ceb));
            chk($sformatf("vec%0d_web", r), 128'(a_web), 128'(vecs[r].exp_web));
            chk($sformatf("vec%0d_rsp", r), 128'(a_rsp_valid), 128'(vecs[r].exp_rsp));
            tick();
        end
        a_valid = 2'b00;

        // Instance B: requester 2 alone, then 0 and 2 together -> 2, 0, 2
        b_write = 3'b000;
        b_addr = {4'd2, 4'd1, 4'd0};
        b_valid = 3'b100;
        #1;
        chk("p3_grant2", 128'(b_ready), 128'(3'b100));
        tick();
        b_valid = 3'b101;
        #1;
        chk("p3_grant0", 128'(b_ready), 128'(3'b001));
        chk("p3_rsp2", 128'(b_rsp_valid), 128'(3'b100));
        tick();
        b_valid = 3'b100;
        #1;
        chk("p3_grant2_again", 128'(b_ready), 128'(3'b100));
        chk("p3_rsp0", 128'(b_rsp_valid), 128'(3'b001));
        tick();
        b_valid = 3'b000;
        #1;
        chk("p3_rsp2_again", 128'(b_rsp_valid), 128'(3'b100));

        // Randomized run on instance B against the reference model (pointer is 0 here)
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; pm[i] = '0;
        end
        ptr = 0; gw = 0; gv = 1'b0; exp_rd = '0;
        for (int c = 0; c < 400; c++) begin
            tick();
            exp_rv = '0;
            if (gv) begin
                ptr = (gw + 1) % 3;
                if (pw[gw]) ref_mem[pa[gw]] = (ref_mem[pa[gw]] & pm[gw]) | (pd[gw] & ~pm[gw]);
                else begin
                    exp_rv[gw] = 1'b1;
                    exp_rd = ref_mem[pa[gw]];
                end
                pv[gw] = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1'b1;
                    pw[i] = ($urandom_range(0, 1) == 1);
                    pa[i] = 4'($urandom_range(0, 3));
                    pd[i] = 16'($urandom);
                    pm[i] = 16'($urandom) & 16'($urandom);
                end
                b_valid[i] = pv[i];
                b_write[i] = pw[i];
                b_addr[i*4 +: 4] = pa[i];
                b_data[i*16 +: 16] = pd[i];
                b_mask[i*16 +: 16] = pm[i];
            end
            #1;
            gv = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (!gv && pv[(ptr + k) % 3]) begin
                    gv = 1'b1;
                    gw = (ptr + k) % 3;
                end
            end
            chk("rnd_ready", 128'(b_ready), gv ? 128'(1) << gw : 128'(0));
            chk("rnd_ceb", 128'(b_ceb), 128'(!gv));
            chk("rnd_web", 128'(b_web), gv ? 128'(!pw[gw]) : 128'(1));
            chk("rnd_addr", 128'(b_sa), gv ? 128'(pa[gw]) : 128'(0));
            chk("rnd_data", 128'(b_sd), gv ? 128'(pd[gw]) : 128'(0));
            chk("rnd_mask", 128'(b_sm), gv ? 128'(pm[gw]) : 128'(0));
            chk("rnd_rsp_valid", 128'(b_rsp_valid), 128'(exp_rv));
            if (exp_rv != 3'b000) chk("rnd_rsp_data", 128'(b_rsp_data), 128'(exp_rd));
        end
        b_valid = 3'b000;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
